// File: rtl/irqregister_n.sv
// Interrupt register for the CAN controller CPU interface: per-source pending,
// enable and overflow bits, a global on/off bit, and a registered IRQ/priority output.
module irqregister_n #(
  parameter int NSRC  = 3,
  parameter bit PULSE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu,
  input  logic [3*NSRC:0]   wdata,
  input  logic [NSRC-1:0]   can_set,
  output logic [3*NSRC:0]   register,
  output logic              irq,
  output logic [2:0]        irqvec
);

  logic [NSRC-1:0] pend_p0, en_p0, ovf_p0;
  logic            onoff_p0;
  logic            req_p1;

  logic [NSRC-1:0] clr_pend, clr_ovf, pend_n, ovf_n, act;
  logic            req;

  function automatic logic [2:0] lowest_idx(input logic [NSRC-1:0] v);
    lowest_idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  // A controller event wins over a CPU clear of the same bit; an overflow
  // is only recorded when the earlier event is still unacknowledged.
  always_comb begin
    clr_pend = cpu ? ~wdata[NSRC-1:0] : '0;
    clr_ovf  = cpu ? ~wdata[3*NSRC-1:2*NSRC] : '0;
    pend_n   = can_set | (pend_p0 & ~clr_pend);
    ovf_n    = (can_set & pend_p0 & ~clr_pend) | (ovf_p0 & ~clr_ovf);
    act      = {NSRC{onoff_p0}} & en_p0 & pend_p0;
    req      = |act;
  end

  // Stage p0: register contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_p0  <= '0;
      en_p0    <= '0;
      ovf_p0   <= '0;
      onoff_p0 <= 1'b0;
    end else begin
      pend_p0 <= pend_n;
      ovf_p0  <= ovf_n;
      if (cpu) begin
        en_p0    <= wdata[2*NSRC-1:NSRC];
        onoff_p0 <= wdata[3*NSRC];
      end
    end
  end

  // Stage p1: host-facing request outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq    <= 1'b0;
      irqvec <= 3'd0;
      req_p1 <= 1'b0;
    end else begin
      req_p1 <= req;
      irqvec <= lowest_idx(act);
      if (PULSE) irq <= req & ~req_p1;
      else       irq <= req;
    end
  end

  assign register = {onoff_p0, ovf_p0, en_p0, pend_p0};

endmodule
